captura_de_requisicao: RTL and testbench

CAPTURA_DE_REQUISICAO -- requirements
Module: captura_de_requisicao

---
 rtl/captura_de_requisicao.sv | 193 +++++++++++++++++++
 tb/tb_captura_de_requisicao.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_de_requisicao.sv
// Request capture: synchronizes switches/buttons, debounces buttons and latches a settled per-channel
// request code for a hold window. Define LIBERACAO_ANTECIPADA_EN to let a release end ACTIVE early.
module captura_de_requisicao #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 4,
    parameter int HOLD_CYCLES     = 1000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] CH,
    input  logic [3:0] BTN,
    output logic [2:0] User0,
    output logic [2:0] User1,
    output logic [2:0] Func0,
    output logic [2:0] Func1,
    output logic       Valid0,
    output logic       Valid1,
    output logic [1:0] state0,
    output logic [1:0] state1
);

    // ValidK is a level, not a handshake: it is high exactly while channel K is ACTIVE,
    // UserK/FuncK are meaningful only while it is high, and there is no back-pressure.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0]  DEB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES);

    logic [7:0]      ch_meta;
    logic [7:0]      ch_sync;
    logic [3:0]      btn_meta;
    logic [3:0]      btn_sync;
    logic [3:0]      btn_deb;
    logic [3:0][7:0] deb_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ch_meta  <= '0;
            ch_sync  <= '0;
            btn_meta <= '1;
            btn_sync <= '1;
        end else begin
            ch_meta  <= CH;
            ch_sync  <= ch_meta;
            btn_meta <= BTN;
            btn_sync <= btn_meta;
        end
    end

    // A button flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles; any agreement restarts.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            btn_deb <= '1;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_sync[i] == btn_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_LAST) begin
                    btn_deb[i] <= btn_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    logic [1:0][2:0] live;
    logic [1:0][2:0] user_live;

    assign live      = {{ch_sync[7], ~btn_deb[2], ~btn_deb[3]},
                        {ch_sync[3], ~btn_deb[0], ~btn_deb[1]}};
    assign user_live = {{ch_sync[4], ch_sync[5], ch_sync[6]},
                        {ch_sync[0], ch_sync[1], ch_sync[2]}};

    logic [2:0] user_o  [2];
    logic [2:0] func_o  [2];
    logic       valid_o [2];
    logic [1:0] state_o [2];

    for (genvar k = 0; k < 2; k++) begin : g_chan
        state_t      state_q;
        state_t      state_nx;
        logic [2:0]  ref_q;
        logic [2:0]  ref_nx;
        logic [3:0]  settle_q;
        logic [3:0]  settle_nx;
        logic [15:0] hold_q;
        logic [15:0] hold_nx;
        logic [2:0]  user_q;
        logic [2:0]  user_nx;
        logic [2:0]  func_q;
        logic [2:0]  func_nx;

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                state_q  <= IDLE;
                ref_q    <= '0;
                settle_q <= '0;
                hold_q   <= '0;
                user_q   <= '0;
                func_q   <= '0;
            end else begin
                state_q  <= state_nx;
                ref_q    <= ref_nx;
                settle_q <= settle_nx;
                hold_q   <= hold_nx;
                user_q   <= user_nx;
                func_q   <= func_nx;
            end
        end

        always_comb begin
            state_nx  = state_q;
            ref_nx    = ref_q;
            settle_nx = settle_q;
            hold_nx   = hold_q;
            user_nx   = user_q;
            func_nx   = func_q;
            case (state_q)
                IDLE: begin
                    if (live[k] != 3'b000) begin
                        state_nx  = ARM;
                        ref_nx    = live[k];
                        settle_nx = SETTLE_LOAD;
                    end
                end
                ARM: begin
                    if (live[k] == 3'b000) begin
                        state_nx  = IDLE;
                        ref_nx    = '0;
                        settle_nx = '0;
                    end else if (live[k] != ref_q) begin
                        ref_nx    = live[k];
                        settle_nx = SETTLE_LOAD;
                    end else if (settle_q <= 4'd1) begin
                        state_nx  = ACTIVE;
                        func_nx   = ref_q;
                        user_nx   = user_live[k];
                        hold_nx   = HOLD_LOAD;
                        settle_nx = '0;
                    end else begin
                        settle_nx = settle_q - 4'd1;
                    end
                end
                ACTIVE: begin
                    if (hold_q <= 16'd1) begin
                        state_nx = RELEASE;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_q - 16'd1;
                    end
`ifdef LIBERACAO_ANTECIPADA_EN
                    if (live[k] == 3'b000) begin
                        state_nx = IDLE;
                        hold_nx  = '0;
                    end
`endif
                end
                RELEASE: begin
                    // Requires a full release before the channel can arm again.
                    if (live[k] == 3'b000) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        assign valid_o[k] = (state_q == ACTIVE);
        assign user_o[k]  = (state_q == ACTIVE) ? user_q : 3'b000;
        assign func_o[k]  = (state_q == ACTIVE) ? func_q : 3'b000;
        assign state_o[k] = state_q;
    end

    assign User0  = user_o[0];
    assign User1  = user_o[1];
    assign Func0  = func_o[0];
    assign Func1  = func_o[1];
    assign Valid0 = valid_o[0];
    assign Valid1 = valid_o[1];
    assign state0 = state_o[0];
    assign state1 = state_o[1];

endmodule

// File: tb/tb_captura_de_requisicao.sv
// Directed bench for captura_de_requisicao: a table of per-phase vectors plus hand-written
// sequences for bounce, staggered buttons, long hold, reset mid-request and release during ACTIVE.
module tb_captura_de_requisicao;

    localparam int DEB  = 4;
    localparam int SET  = 2;
    localparam int HOLD = 10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic       CLK;
    logic       RST_N;
    logic [7:0] CH;
    logic [3:0] BTN;
    logic [2:0] User0;
    logic [2:0] User1;
    logic [2:0] Func0;
    logic [2:0] Func1;
    logic       Valid0;
    logic       Valid1;
    logic [1:0] state0;
    logic [1:0] state1;

    int n_cmp = 0;
    int n_bad = 0;

    captura_de_requisicao #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CH    (CH),
        .BTN   (BTN),
        .User0 (User0),
        .User1 (User1),
        .Func0 (Func0),
        .Func1 (Func1),
        .Valid0(Valid0),
        .Valid1(Valid1),
        .state0(state0),
        .state1(state1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [7:0] ch;
        logic [3:0] btn;
        int         steps;
        logic [17:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic logic [8:0] chn(input logic v, input logic [2:0] u,
                                       input logic [2:0] f, input logic [1:0] s);
        return {v, u, f, s};
    endfunction

    function automatic logic [17:0] observed();
        return {Valid0, User0, Func0, state0, Valid1, User1, Func1, state1};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got v0/u0/f0/s0/v1/u1/f1/s1=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input string name, input logic [7:0] ch,
                           input logic [3:0] btn, input int steps, input logic [17:0] exp);
        vecs[i].name  = name;
        vecs[i].ch    = ch;
        vecs[i].btn   = btn;
        vecs[i].steps = steps;
        vecs[i].exp   = exp;
    endtask

    logic [8:0] idle_c;
    logic [8:0] c1_after_drop;
    logic [8:0] c1_after_end;
    logic [8:0] both_after_end;
    int         rises;
    int         rise_at;
    int         width;
    int         saw_010;
    int         f_at_rise;
    int         v0_seen;
    logic       prev_v;

    initial begin
        RST_N = 1'b0;
        CH    = 8'h00;
        BTN   = 4'hF;

        idle_c = chn(1'b0, 3'd0, 3'd0, S_IDLE);
`ifdef LIBERACAO_ANTECIPADA_EN
        c1_after_drop  = idle_c;
        c1_after_end   = idle_c;
        both_after_end = idle_c;
`else
        c1_after_drop  = chn(1'b1, 3'b110, 3'b100, S_ACT);
        c1_after_end   = chn(1'b0, 3'd0, 3'd0, S_REL);
        both_after_end = chn(1'b0, 3'd0, 3'd0, S_REL);
`endif

        // Phases are cumulative: apply inputs, advance the given cycles, then compare.
        set_vec(0,  "c0_arm",        8'h05, 4'hD, 8,  {chn(1'b0, 3'd0, 3'd0, S_ARM), idle_c});
        set_vec(1,  "c0_rise",       8'h05, 4'hD, 1,  {chn(1'b1, 3'b101, 3'b001, S_ACT), idle_c});
        set_vec(2,  "c0_frozen_sw",  8'h00, 4'hD, 1,  {chn(1'b1, 3'b101, 3'b001, S_ACT), idle_c});
        set_vec(3,  "c0_mid",        8'h00, 4'hD, 7,  {chn(1'b1, 3'b101, 3'b001, S_ACT), idle_c});
        set_vec(4,  "c0_last",       8'h00, 4'hD, 1,  {chn(1'b1, 3'b101, 3'b001, S_ACT), idle_c});
        set_vec(5,  "c0_end",        8'h00, 4'hD, 1,  {chn(1'b0, 3'd0, 3'd0, S_REL), idle_c});
        set_vec(6,  "c0_held",       8'h00, 4'hD, 20, {chn(1'b0, 3'd0, 3'd0, S_REL), idle_c});
        set_vec(7,  "c0_rel_deb",    8'h00, 4'hF, 6,  {chn(1'b0, 3'd0, 3'd0, S_REL), idle_c});
        set_vec(8,  "c0_idle",       8'h00, 4'hF, 1,  {idle_c, idle_c});
        set_vec(9,  "c0_repress",    8'h06, 4'hD, 9,  {chn(1'b1, 3'b011, 3'b001, S_ACT), idle_c});
        set_vec(10, "c0_repress_end", 8'h06, 4'hD, 10, {chn(1'b0, 3'd0, 3'd0, S_REL), idle_c});
        set_vec(11, "c0_back_idle",  8'h00, 4'hF, 7,  {idle_c, idle_c});
        set_vec(12, "c1_arm",        8'hB0, 4'hF, 4,  {idle_c, chn(1'b0, 3'd0, 3'd0, S_ARM)});
        set_vec(13, "c1_rise",       8'hB0, 4'hF, 1,  {idle_c, chn(1'b1, 3'b110, 3'b100, S_ACT)});
        set_vec(14, "c1_after_drop", 8'h00, 4'hF, 9,  {idle_c, c1_after_drop});
        set_vec(15, "c1_end",        8'h00, 4'hF, 1,  {idle_c, c1_after_end});
        set_vec(16, "c1_idle",       8'h00, 4'hF, 1,  {idle_c, idle_c});
        set_vec(17, "both_rise",     8'h88, 4'hF, 5,  {chn(1'b1, 3'd0, 3'b100, S_ACT),
                                                      chn(1'b1, 3'd0, 3'b100, S_ACT)});
        set_vec(18, "both_end",      8'h00, 4'hF, 10, {both_after_end[8:0], both_after_end[8:0]});
        set_vec(19, "both_idle",     8'h00, 4'hF, 1,  {idle_c, idle_c});

        // Reset with raw inputs active: everything must read idle.
        CH  = 8'hFF;
        BTN = 4'h0;
        step(3);
        check_vec("reset_state", observed(), {idle_c, idle_c});
        CH  = 8'h00;
        BTN = 4'hF;
        step(2);
        RST_N = 1'b1;
        step(1);
        check_vec("after_reset_idle", observed(), {idle_c, idle_c});

        for (int i = 0; i < NV; i++) begin
            CH  = vecs[i].ch;
            BTN = vecs[i].btn;
            step(vecs[i].steps);
            check_vec(vecs[i].name, observed(), vecs[i].exp);
        end

        // Bouncing BTN[0]: 3-cycle pulses never survive a 4-cycle debounce.
        v0_seen = 0;
        for (int i = 0; i < 20; i++) begin
            BTN = {3'b111, (((i / 3) % 2) == 0) ? 1'b0 : 1'b1};
            step(1);
            if (Valid0 || state0 != S_IDLE) v0_seen++;
        end
        BTN = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (Valid0 || state0 != S_IDLE) v0_seen++;
        end
        check_int("bounce_never_arms", v0_seen, 0);

        // BTN[2] then BTN[3] one cycle later, held ~30 cycles: one capture of 011.
        BTN = 4'b1011;
        step(1);
        BTN = 4'b0011;
        rises = 0; rise_at = -1; width = 0; saw_010 = 0; f_at_rise = -1; v0_seen = 0;
        prev_v = 1'b0;
        for (int n = 2; n <= 31; n++) begin
            step(1);
            if (Valid1 && !prev_v) begin
                rises++;
                rise_at = n;
                f_at_rise = int'(Func1);
            end
            if (Valid1) width++;
            if (Func1 == 3'b010) saw_010++;
            if (Valid0) v0_seen++;
            prev_v = Valid1;
        end
        check_int("stagger_rises", rises, 1);
        check_int("stagger_rise_cycle", rise_at, 2 + DEB + SET + 2);
        check_int("stagger_func", f_at_rise, 3);
        check_int("stagger_never_010", saw_010, 0);
        check_int("held_pulse_width", width, HOLD);
        check_int("held_c0_quiet", v0_seen, 0);
        check_int("held_c1_release_state", int'(state1), int'(S_REL));
        BTN = 4'hF;
        step(8);
        check_int("stagger_back_idle", int'(state1), int'(S_IDLE));

        // Reset on the 4th ACTIVE cycle.
        BTN = 4'hD;
        step(9);
        check_vec("rst_pre_active", observed(), {chn(1'b1, 3'd0, 3'b001, S_ACT), idle_c});
        step(3);
        RST_N = 1'b0;
        step(1);
        check_vec("rst_mid_active", observed(), {idle_c, idle_c});
        BTN = 4'hF;
        step(1);
        RST_N = 1'b1;
        v0_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (Valid0 || state0 != S_IDLE) v0_seen++;
        end
        check_int("rst_no_resume", v0_seen, 0);

        // Reset during ARM.
        BTN = 4'hD;
        step(7);
        check_int("rst_pre_arm", int'(state0), int'(S_ARM));
        RST_N = 1'b0;
        step(1);
        check_vec("rst_mid_arm", observed(), {idle_c, idle_c});
        BTN = 4'hF;
        step(1);
        RST_N = 1'b1;
        step(2);

        // Release on the 3rd ACTIVE cycle.
        BTN = 4'hD;
        step(9);
        check_int("early_rise", int'(Valid0), 1);
        step(2);
        BTN = 4'hF;
`ifdef LIBERACAO_ANTECIPADA_EN
        step(6);
        check_int("early_still_high", int'(Valid0), 1);
        step(1);
        check_vec("early_drop", observed(), {idle_c, idle_c});
`else
        step(7);
        check_int("full_hold_still_high", int'(Valid0), 1);
        step(1);
        check_vec("full_hold_drop", observed(), {chn(1'b0, 3'd0, 3'd0, S_REL), idle_c});
        step(1);
        check_int("full_hold_idle", int'(state0), int'(S_IDLE));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
